// File: rtl/calc_sequencer.sv
// calc_sequencer: keypad calculator sequencer (operand entry, ALU handshake, display refresh).
// Define CALC_CHAIN_EN to let an op key in the result state chain the result into operand A.
module calc_sequencer #(
  parameter int MAX_DIGITS  = 4,
  parameter int ALU_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_digit_pulse,
  input  logic [3:0]  key_digit,
  input  logic        key_op_pulse,
  input  logic [1:0]  key_op,
  input  logic        key_eq_pulse,
  input  logic        alu_done,
  input  logic        alu_err,
  input  logic [15:0] res_bcd,
  input  logic        disp_busy,
  output logic [15:0] op_a_bcd,
  output logic [15:0] op_b_bcd,
  output logic [1:0]  op_sel,
  output logic        alu_start,
  output logic [1:0]  disp_sel,
  output logic        disp_req,
  output logic [2:0]  state_o,
  output logic [2:0]  digit_cnt
);
  typedef enum logic [2:0] {S_A = 3'd0, S_B = 3'd1, S_CALC = 3'd2, S_RES = 3'd3, S_ERR = 3'd4} state_t;
`ifdef CALC_CHAIN_EN
  localparam bit CHAIN = 1'b1;
`else
  localparam bit CHAIN = 1'b0;
`endif
  localparam logic [2:0] MAXD = 3'(MAX_DIGITS);
  localparam logic [7:0] TMO  = 8'(ALU_TIMEOUT);
  state_t      state_q, state_d;
  logic [15:0] a_q, a_d, b_q, b_d;
  logic [1:0]  sel_q, sel_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  to_q, to_d;
  logic        start_q, start_d, req_q, req_d, pend_q, pend_d;
  logic        eq, op, dig_ok, room, acc, fire;
  // one key per cycle: eq beats op beats digit
  assign eq     = key_eq_pulse;
  assign op     = key_op_pulse & ~key_eq_pulse;
  assign dig_ok = key_digit_pulse & ~key_op_pulse & ~key_eq_pulse & (key_digit <= 4'd9);
  assign room   = cnt_q < MAXD;
  assign fire   = pend_q & ~disp_busy;
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    start_d = 1'b0;
    acc     = 1'b0;
    case (state_q)
      S_A: begin
        if (op) begin
          sel_d = key_op; b_d = '0; cnt_d = '0; state_d = S_B; acc = 1'b1;
        end else if (dig_ok && room) begin
          a_d = {a_q[11:0], key_digit}; cnt_d = cnt_q + 3'd1; acc = 1'b1;
        end
      end
      S_B: begin
        if (eq) begin
          start_d = 1'b1; to_d = '0; state_d = S_CALC; acc = 1'b1;
        end else if (op) begin
          sel_d = key_op; acc = 1'b1;
        end else if (dig_ok && room) begin
          b_d = {b_q[11:0], key_digit}; cnt_d = cnt_q + 3'd1; acc = 1'b1;
        end
      end
      S_CALC: begin
        if (alu_done) state_d = alu_err ? S_ERR : S_RES;
        else if (to_q == TMO) state_d = S_ERR;
        else to_d = to_q + 8'd1;
      end
      S_RES: begin
        if (dig_ok) begin
          a_d = {12'd0, key_digit}; b_d = '0; cnt_d = 3'd1; state_d = S_A; acc = 1'b1;
        end else if (op && CHAIN) begin
          a_d = res_bcd; b_d = '0; cnt_d = '0; sel_d = key_op; state_d = S_B; acc = 1'b1;
        end
      end
      S_ERR: begin
        if (key_digit_pulse | key_op_pulse | key_eq_pulse) begin
          a_d = '0; b_d = '0; sel_d = '0; cnt_d = '0; state_d = S_A;
        end
      end
      default: state_d = S_A;
    endcase
    req_d  = fire;
    pend_d = (pend_q & ~fire) | acc | (state_d != state_q);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_A;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      to_q    <= '0;
      start_q <= 1'b0;
      req_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      start_q <= start_d;
      req_q   <= req_d;
      pend_q  <= pend_d;
    end
  end
  assign op_a_bcd  = a_q;
  assign op_b_bcd  = b_q;
  assign op_sel    = sel_q;
  assign alu_start = start_q;
  assign disp_req  = req_q;
  assign state_o   = state_q;
  assign digit_cnt = cnt_q;
  assign disp_sel  = (state_q == S_A) ? 2'd0 : (state_q == S_RES) ? 2'd2 : (state_q == S_ERR) ? 2'd3 : 2'd1;
endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: directed bench for calc_sequencer with an ALU-start scoreboard.
module tb_calc_sequencer;
  logic        clk = 1'b0, rst = 1'b1;
  logic        key_digit_pulse = 1'b0, key_op_pulse = 1'b0, key_eq_pulse = 1'b0;
  logic [3:0]  key_digit = '0;
  logic [1:0]  key_op = '0;
  logic        alu_done = 1'b0, alu_err = 1'b0, disp_busy = 1'b0;
  logic [15:0] res_bcd = '0;
  logic [15:0] op_a_bcd, op_b_bcd;
  logic [1:0]  op_sel, disp_sel;
  logic        alu_start, disp_req;
  logic [2:0]  state_o, digit_cnt;
  typedef struct packed {logic [15:0] a; logic [15:0] b; logic [1:0] sel;} start_t;
  start_t exp_q[$];
  int passed = 0, total = 0, req_cnt = 0;
  calc_sequencer dut (
    .clk(clk), .rst(rst), .key_digit_pulse(key_digit_pulse), .key_digit(key_digit),
    .key_op_pulse(key_op_pulse), .key_op(key_op), .key_eq_pulse(key_eq_pulse),
    .alu_done(alu_done), .alu_err(alu_err), .res_bcd(res_bcd), .disp_busy(disp_busy),
    .op_a_bcd(op_a_bcd), .op_b_bcd(op_b_bcd), .op_sel(op_sel), .alu_start(alu_start),
    .disp_sel(disp_sel), .disp_req(disp_req), .state_o(state_o), .digit_cnt(digit_cnt)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (disp_req) req_cnt++;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask
  task automatic press(input logic dp, input logic [3:0] d, input logic opp, input logic [1:0] o, input logic e);
    key_digit_pulse = dp; key_digit = d; key_op_pulse = opp; key_op = o; key_eq_pulse = e;
    @(negedge clk);
    key_digit_pulse = 1'b0; key_op_pulse = 1'b0; key_eq_pulse = 1'b0;
  endtask
  task automatic digit(input logic [3:0] d);
    press(1'b1, d, 1'b0, 2'd0, 1'b0); idle(3);
  endtask
  task automatic opk(input logic [1:0] o);
    press(1'b0, 4'd0, 1'b1, o, 1'b0); idle(3);
  endtask
  task automatic start_chk;
    start_t e;
    int n = 0;
    while (!alu_start && n < 5) begin @(negedge clk); n++; end
    chk("alu_start seen", {31'd0, alu_start}, 32'd1);
    if (exp_q.size() == 0) chk("scoreboard empty", 32'd1, 32'd0);
    else begin
      e = exp_q.pop_front();
      chk("start op_a", {16'd0, op_a_bcd}, {16'd0, e.a});
      chk("start op_b", {16'd0, op_b_bcd}, {16'd0, e.b});
      chk("start op_sel", {30'd0, op_sel}, {30'd0, e.sel});
    end
    @(negedge clk);
    chk("alu_start one cycle", {31'd0, alu_start}, 32'd0);
  endtask
  task automatic reset_pulse;
    rst = 1'b1; idle(2); rst = 1'b0; idle(1);
  endtask
  initial begin
    int c0, n;
    idle(2);
    chk("rst state", {29'd0, state_o}, 32'd0);
    chk("rst op_a", {16'd0, op_a_bcd}, 32'd0);
    chk("rst op_b", {16'd0, op_b_bcd}, 32'd0);
    chk("rst op_sel", {30'd0, op_sel}, 32'd0);
    chk("rst cnt", {29'd0, digit_cnt}, 32'd0);
    chk("rst start/req/sel", {28'd0, alu_start, disp_req, disp_sel}, 32'd0);
    rst = 1'b0; idle(1);
    c0 = req_cnt;
    digit(4'd1); digit(4'd2); digit(4'd3);
    chk("abc op_a", {16'd0, op_a_bcd}, 32'h0123);
    chk("abc cnt", {29'd0, digit_cnt}, 32'd3);
    chk("abc reqs", req_cnt - c0, 32'd3);
    chk("abc disp_sel", {30'd0, disp_sel}, 32'd0);
    reset_pulse();
    c0 = req_cnt;
    digit(4'd12);
    chk("digit 12 ignored", {16'd0, op_a_bcd}, 32'd0);
    chk("digit 12 no req", req_cnt - c0, 32'd0);
    digit(4'd9); digit(4'd8); digit(4'd7); digit(4'd6);
    c0 = req_cnt;
    digit(4'd5);
    chk("max op_a", {16'd0, op_a_bcd}, 32'h9876);
    chk("max cnt", {29'd0, digit_cnt}, 32'd4);
    chk("5th digit no req", req_cnt - c0, 32'd0);
    reset_pulse();
    digit(4'd1); digit(4'd2);
    press(1'b0, 4'd0, 1'b0, 2'd0, 1'b1); idle(2);
    chk("eq in S_A ignored", {29'd0, state_o}, 32'd0);
    opk(2'd2);
    chk("op -> S_B", {29'd0, state_o}, 32'd1);
    chk("op_sel 2", {30'd0, op_sel}, 32'd2);
    chk("B cnt cleared", {29'd0, digit_cnt}, 32'd0);
    digit(4'd3); digit(4'd4);
    chk("op_b 34", {16'd0, op_b_bcd}, 32'h0034);
    exp_q.push_back('{a: 16'h0012, b: 16'h0034, sel: 2'd2});
    press(1'b0, 4'd0, 1'b0, 2'd0, 1'b1);
    start_chk();
    chk("calc state", {29'd0, state_o}, 32'd2);
    alu_done = 1'b1; res_bcd = 16'h0046; @(negedge clk); alu_done = 1'b0; idle(2);
    chk("res state", {29'd0, state_o}, 32'd3);
    chk("res disp_sel", {30'd0, disp_sel}, 32'd2);
    press(1'b0, 4'd0, 1'b0, 2'd0, 1'b1); idle(2);
    chk("eq in S_RES ignored", {29'd0, state_o}, 32'd3);
    opk(2'd1);
`ifdef CALC_CHAIN_EN
    chk("chain state", {29'd0, state_o}, 32'd1);
    chk("chain op_a", {16'd0, op_a_bcd}, 32'h0046);
    chk("chain op_b", {16'd0, op_b_bcd}, 32'd0);
`else
    chk("no chain state", {29'd0, state_o}, 32'd3);
    chk("no chain op_a", {16'd0, op_a_bcd}, 32'h0012);
    digit(4'd5);
    chk("new calc state", {29'd0, state_o}, 32'd0);
    chk("new calc op_a", {16'd0, op_a_bcd}, 32'h0005);
    chk("new calc op_b", {16'd0, op_b_bcd}, 32'd0);
    chk("new calc cnt", {29'd0, digit_cnt}, 32'd1);
    opk(2'd0);
`endif
    press(1'b0, 4'd0, 1'b0, 2'd0, 1'b1);
    n = 0;
    while (state_o != 3'd4 && n < 400) begin @(negedge clk); n++; end
    chk("timeout cycles", n, 32'd256);
    chk("err disp_sel", {30'd0, disp_sel}, 32'd3);
    digit(4'd7);
    chk("err exit state", {29'd0, state_o}, 32'd0);
    chk("err exit op_a", {16'd0, op_a_bcd}, 32'd0);
    chk("err exit sel/cnt", {27'd0, op_sel, digit_cnt}, 32'd0);
    digit(4'd1); opk(2'd3); digit(4'd5);
    c0 = req_cnt;
    disp_busy = 1'b1;
    exp_q.push_back('{a: 16'h0001, b: 16'h0005, sel: 2'd3});
    press(1'b1, 4'd2, 1'b0, 2'd0, 1'b1);
    start_chk();
    chk("eq+digit op_b", {16'd0, op_b_bcd}, 32'h0005);
    idle(2);
    alu_done = 1'b1; alu_err = 1'b1; @(negedge clk); alu_done = 1'b0; alu_err = 1'b0;
    chk("alu_err state", {29'd0, state_o}, 32'd4);
    idle(5);
    chk("busy no req", req_cnt - c0, 32'd0);
    disp_busy = 1'b0; idle(4);
    chk("merged req", req_cnt - c0, 32'd1);
    digit(4'd0); digit(4'd4); opk(2'd1); digit(4'd2);
    press(1'b0, 4'd0, 1'b0, 2'd0, 1'b1);
    #2 rst = 1'b1; #1;
    chk("mid-calc rst state", {29'd0, state_o}, 32'd0);
    chk("mid-calc rst ops", {op_a_bcd, op_b_bcd}, 32'd0);
    chk("mid-calc rst misc", {24'd0, op_sel, alu_start, disp_req, disp_sel, digit_cnt}, 32'd0);
    @(negedge clk); rst = 1'b0;
    alu_done = 1'b1; res_bcd = 16'h0099; @(negedge clk); alu_done = 1'b0; idle(1);
    chk("late done ignored", {29'd0, state_o}, 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
